// File: rtl/uart_receiver_ovs.sv
// rtl/uart_receiver_ovs.sv - oversampling UART receive engine with break and char timeout
// Frames are timed in enable ticks; one status-tagged word is pushed per character or break.
module uart_receiver_ovs #(
  parameter int OVS      = 16,
  parameter int MAJORITY = 1,
  parameter int CT_W     = 10
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic            enable,
  input  logic [7:0]      lcr,
  input  logic            srx_pad_i,
  input  logic            rx_reset,
  input  logic            lsr_mask,
  input  logic            fifo_full,
  input  logic            rf_pop,
  input  logic            rf_empty,
  output logic            rf_push,
  output logic [10:0]     rf_data_in,
  output logic            overrun,
  output logic            break_det,
  output logic [CT_W-1:0] counter_t,
  output logic [2:0]      rstate
);

  localparam int RC_W = $clog2(OVS);
  localparam logic [RC_W-1:0] LAST_TICK = RC_W'(OVS - 1);
  localparam logic [RC_W-1:0] SAMP_TICK = RC_W'((MAJORITY != 0) ? (OVS / 2 + 1) : (OVS / 2));
  localparam logic [RC_W-1:0] MAJ_T0    = RC_W'(OVS / 2 - 1);
  localparam logic [RC_W-1:0] MAJ_T1    = RC_W'(OVS / 2);
  localparam logic [CT_W-1:0] TOC_RST   = CT_W'(4 * 10 * OVS - 1);
  localparam logic [CT_W-1:0] BRC_RST   = CT_W'(10 * OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_PUSH   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic             r_line_ok;
  logic [RC_W-1:0]  r_rcnt;
  logic [2:0]       r_bitidx;
  logic [7:0]       r_data;
  logic             r_brk;
  logic             r_perr;
  logic             r_ferr;
  logic             r_s1;
  logic             r_s2;
  logic [CT_W-1:0]  r_counter_b;
  logic [CT_W-1:0]  r_counter_t;
  logic             r_overrun;
  logic             r_break_det;

  logic [3:0]       w_char_bits;
  logic [CT_W-1:0]  w_toc;
  logic [CT_W-1:0]  w_brc;
  logic [2:0]       w_last_idx;
  logic             w_maj;
  logic             w_bit;
  logic             w_samp;
  logic             w_last;
  logic             w_brk_hit;
  logic             w_par_odd;
  logic             w_perr;
  logic             w_lcr_unused;

  assign w_lcr_unused = ^lcr[7:6];

  // Frame length in bit periods: start + data + optional parity + stop bits.
  assign w_char_bits = 4'd1 + ({2'b00, lcr[1:0]} + 4'd5) + {3'b000, lcr[3]} + (lcr[2] ? 4'd2 : 4'd1);
  assign w_toc       = CT_W'(32'(w_char_bits) * 32'(4 * OVS) - 32'd1);
  assign w_brc       = w_toc >> 2;
  assign w_last_idx  = {1'b0, lcr[1:0]} + 3'd4;

  assign w_maj  = (r_s1 & r_s2) | (r_s1 & r_rx_s) | (r_s2 & r_rx_s);
  assign w_bit  = (MAJORITY != 0) ? w_maj : r_rx_s;
  assign w_samp = (r_rcnt == SAMP_TICK);
  assign w_last = (r_rcnt == LAST_TICK);

  assign w_par_odd = ^{r_data, w_bit};
  assign w_perr    = lcr[5] ? (w_bit != ~lcr[4]) : (lcr[4] ? w_par_odd : ~w_par_odd);

  // Fires for exactly one clk: break_det rises on the following edge and masks it.
  assign w_brk_hit = ~r_rx_s & ~r_break_det & (r_counter_b == '0);

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= srx_pad_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_line_ok <= 1'b1;
    end else if (rx_reset || w_brk_hit) begin
      r_line_ok <= 1'b0;
    end else if (r_rx_s) begin
      r_line_ok <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_counter_b <= BRC_RST;
      r_break_det <= 1'b0;
    end else begin
      if (r_rx_s) begin
        r_counter_b <= w_brc;
      end else if (enable && (r_counter_b != '0)) begin
        r_counter_b <= r_counter_b - 1'b1;
      end
      if (r_rx_s) begin
        r_break_det <= 1'b0;
      end else if (w_brk_hit) begin
        r_break_det <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_counter_t <= TOC_RST;
    end else if (rf_push || rf_pop || rf_empty) begin
      r_counter_t <= w_toc;
    end else if (enable && (r_counter_t != '0)) begin
      r_counter_t <= r_counter_t - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_overrun <= 1'b0;
    end else if (rf_push && fifo_full) begin
      r_overrun <= 1'b1;
    end else if (lsr_mask) begin
      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rcnt   <= '0;
      r_bitidx <= '0;
      r_data   <= '0;
      r_brk    <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
    end else if (w_brk_hit && !rx_reset) begin
      r_data <= '0;
      r_brk  <= 1'b1;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else if (enable) begin
      if (r_state == S_IDLE) begin
        // The tick that detects the start edge counts as tick 0 of the start bit.
        r_rcnt   <= RC_W'(1);
        r_bitidx <= '0;
        r_data   <= '0;
        r_brk    <= 1'b0;
        r_perr   <= 1'b0;
        r_ferr   <= 1'b0;
      end else if (r_state != S_PUSH) begin
        r_rcnt <= w_last ? '0 : r_rcnt + 1'b1;
        if (r_rcnt == MAJ_T0) r_s1 <= r_rx_s;
        if (r_rcnt == MAJ_T1) r_s2 <= r_rx_s;
        if (w_samp) begin
          case (r_state)
            S_DATA:   r_data[r_bitidx] <= w_bit;
            S_PARITY: r_perr <= w_perr;
            S_STOP:   r_ferr <= ~w_bit;
            default:  ;
          endcase
        end
        if ((r_state == S_DATA) && w_last) r_bitidx <= r_bitidx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (rx_reset) begin
      w_next = S_IDLE;
    end else if (w_brk_hit) begin
      w_next = S_PUSH;
    end else begin
      case (r_state)
        S_IDLE:   if (enable && !r_rx_s && r_line_ok) w_next = S_START;
        S_START: begin
          if (enable && w_samp && w_bit) w_next = S_IDLE;
          else if (enable && w_last)     w_next = S_DATA;
        end
        // >= rather than == so a mid-frame lcr change cannot strand the FSM in DATA.
        S_DATA:   if (enable && w_last && (r_bitidx >= w_last_idx)) w_next = lcr[3] ? S_PARITY : S_STOP;
        S_PARITY: if (enable && w_last) w_next = S_STOP;
        S_STOP:   if (enable && w_samp) w_next = S_PUSH;
        S_PUSH:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rf_push    = 1'b0;
    rf_data_in = '0;
    if (r_state == S_PUSH) begin
      rf_push    = 1'b1;
      rf_data_in = {r_data, r_brk, r_perr, r_ferr};
    end
  end

  assign rstate    = r_state;
  assign overrun   = r_overrun;
  assign break_det = r_break_det;
  assign counter_t = r_counter_t;

endmodule
